mips_inst_encoder: RTL and testbench
====================================

// Module: mips_inst_encoder
// PURPOSE
// - Inverse of the instruction decoder. Takes decoder_output_t records plus their PC and re-encodes each one into a 32-bit MIPS word.
// - Buffers results in a small FIFO with valid/ready on both sides.
// - Sits on the commit path and feeds the trace port / self-check: the bench compares each out_word against the fetched instruction word.
// PARAMETERS
// - DEPTH      4   FIFO entries; power of 2, >=2
// - CNT_WIDTH  16  width of the encoded/dropped/error counters; they saturate
// PORTS
// - clk          in   1          clock
// - rst          in   1          synchronous, active-high reset
// - in_valid     in   1          in_dec/in_pc are valid
// - in_ready     out  1          = !full; a transfer happens when in_valid && in_ready
// - in_pc        in   ADDR_WIDTH PC of the instruction
// - in_dec       in   decoder_output_t  decoded record
// - out_valid    out  1          FIFO head is valid
// - out_ready    in   1          consumer accepts the head
// - out_word     out  32         re-encoded instruction; 0 when out_err
// - out_pc       out  ADDR_WIDTH PC of the head entry
// - out_err      out  1          head entry could not be encoded
// - cnt_encoded  out  CNT_WIDTH  entries pushed with err=0
// - cnt_dropped  out  CNT_WIDTH  transfers with in_dec.valid=0
// - cnt_error    out  CNT_WIDTH  entries pushed with err=1
// BEHAVIOUR
// - Reset: FIFO empty, out_valid=0, out_word/out_pc/out_err=0, all counters 0, in_ready=1 in the first cycle after reset.
// - Mid-operation reset discards every entry; a transfer on the reset cycle is lost.
// - Transfer with in_dec.valid=0: consumed, not pushed, cnt_dropped++.
// - Other transfers: encoded combinationally and written at the clock edge. out_valid is high the next cycle, so latency is 1.
// - FIFO read: out_valid && out_ready pops the head.
// - Simultaneous push and pop: allowed when not full; occupancy is unchanged.
// - No bypass: when full, in_ready=0 even if out_ready=1.
// - Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and the rest are equal; empty = pointers equal.
// - Encoding is selected from alu_ctl, is_mem_access, mem_action, is_jump, is_jump_reg, uses_immediate, uses_rw:
//   - R-type arithmetic/logic (ADD..NOR, SLT, SLTU, SLLV/SRLV/SRAV, no immediate): op 0, fields {rs,rt,rw}, shamt 0, matching funct.
//   - SLL/SRL/SRA with immediate: rt field <= rs_addr, rd <= rw_addr, shamt <= immediate[4:0], rs field 0.
//   - JR: funct 08, rs only. JALR: funct 09, rd=31.
//   - I-type: ADD->addi(08), ADDU->addiu(09), AND->andi(0c), OR->ori(0d), XOR->xori(0e), SLT->slti(0a), SLTU->sltiu(0b). rt <= rw_addr, imm <= immediate[15:0].
//   - OR with uses_rs=0, immediate[15:0]==0 and immediate!=0 -> lui(0f), imm <= immediate[31:16]. immediate==0 encodes as ori.
//   - Memory: READ -> lw(23), WRITE -> sw(2b). For sw, rt <= rt_addr.
//   - Branches: BEQ 04, BNE 05, BLEZ 06 (rt=0), BGTZ 07 (rt=0), BLTZ 01 (rt=0), BGEZ 01 (rt=1).
//     - off = (branch_target - in_pc - 4) computed in ADDR_WIDTH+1 bits signed; imm <= off[17:2].
//   - j(02) when is_jump && !is_jump_reg && !uses_rw; jal(03) when uses_rw and rw_addr=31. index <= branch_target[27:2].
//   - MTC0_PASS/FAIL/DONE: op 10, rs=5'h04, rt <= rt_addr, rd = 17/18/19, low 11 bits 0.
// - Error (err=1, word 0, pushed, cnt_error++) when:
//   - alu_ctl is NOP and not j;
//   - no mapping exists;
//   - branch offset off[1:0]!=0 or off is outside the signed 18-bit range;
//   - shamt immediate > 31;
//   - I-type immediate does not fit its sign/zero extension.
// - Counters increment on the transfer edge and saturate at all ones.
// STRUCTURE
// - Shared package (mips_core_pkg): opcode and funct localparams (OP_RTYPE, OP_LW, FN_ADD, ...) and an encode-result struct {logic err; logic [31:0] word;}.
// - Sub-module mips_enc_fifo (DEPTH, payload = {pc, err, word}) is the natural split.
// - The encoder itself is one always_comb case on alu_ctl.
// TESTING
// - add $3,$1,$2 (ALUCTL_ADD, rs=1, rt=2, rw=3) -> out_word 32'h00221820, out_err=0, out_valid one cycle after the transfer.
// - beq, pc=0x100, target=0x0F0, rs=4, rt=5 -> 32'h1085FFFB.
//   - Same record with target=0x0F2 -> out_err=1, out_word=0, cnt_error=1.
// - lui $8,0x1234 (OR, immediate 32'h12340000, uses_rs=0) -> 32'h3C081234.
//   - ori $8,$0,0 -> 32'h34080000.
// - Backpressure: out_ready=0, push DEPTH records -> in_ready=0 after the last one.
//   - Then out_ready=1 with in_valid=1 for 20 cycles -> in-order output, nothing lost, pointers wrap.
// - in_dec.valid=0 for 3 transfers -> no push, cnt_dropped=3, out_valid stays 0.
// - Reset asserted with 2 entries queued and a transfer on the same cycle -> next cycle out_valid=0, all counters 0.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared MIPS encoding constants, decoded-instruction record and word builders.
// Used by the commit-path re-encoder and its trace FIFO.
package mips_core_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic [4:0] {
    ALUCTL_NOP, ALUCTL_ADD, ALUCTL_ADDU, ALUCTL_SUB, ALUCTL_SUBU,
    ALUCTL_AND, ALUCTL_OR, ALUCTL_XOR, ALUCTL_NOR, ALUCTL_SLT, ALUCTL_SLTU,
    ALUCTL_SLL, ALUCTL_SRL, ALUCTL_SRA, ALUCTL_SLLV, ALUCTL_SRLV, ALUCTL_SRAV,
    ALUCTL_BEQ, ALUCTL_BNE, ALUCTL_BLEZ, ALUCTL_BGTZ, ALUCTL_BLTZ, ALUCTL_BGEZ,
    ALUCTL_MTC0_PASS, ALUCTL_MTC0_FAIL, ALUCTL_MTC0_DONE
  } alu_ctl_t;

  typedef enum logic {MEM_READ, MEM_WRITE} mem_action_t;

  typedef struct packed {
    logic                  valid;
    alu_ctl_t              alu_ctl;
    logic [4:0]            rs_addr;
    logic [4:0]            rt_addr;
    logic [4:0]            rw_addr;
    logic                  uses_rs;
    logic                  uses_rw;
    logic                  uses_immediate;
    logic [31:0]           immediate;
    logic                  is_mem_access;
    mem_action_t           mem_action;
    logic                  is_jump;
    logic                  is_jump_reg;
    logic [ADDR_WIDTH-1:0] branch_target;
  } decoder_output_t;

  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } enc_result_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI   = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f, OP_COP0   = 6'h10, OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27, FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;

  localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1, RS_MTC0 = 5'h04;
  localparam logic [4:0] C0_PASS = 5'd17, C0_FAIL = 5'd18, C0_DONE = 5'd19;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic logic [5:0] alu_funct(input alu_ctl_t a);
    logic [5:0] fn;
    fn = FN_SLL;
    case (a)
      ALUCTL_ADD:  fn = FN_ADD;
      ALUCTL_ADDU: fn = FN_ADDU;
      ALUCTL_SUB:  fn = FN_SUB;
      ALUCTL_SUBU: fn = FN_SUBU;
      ALUCTL_AND:  fn = FN_AND;
      ALUCTL_OR:   fn = FN_OR;
      ALUCTL_XOR:  fn = FN_XOR;
      ALUCTL_NOR:  fn = FN_NOR;
      ALUCTL_SLT:  fn = FN_SLT;
      ALUCTL_SLTU: fn = FN_SLTU;
      ALUCTL_SRL:  fn = FN_SRL;
      ALUCTL_SRA:  fn = FN_SRA;
      ALUCTL_SLLV: fn = FN_SLLV;
      ALUCTL_SRLV: fn = FN_SRLV;
      ALUCTL_SRAV: fn = FN_SRAV;
      default:     fn = FN_SLL;
    endcase
    return fn;
  endfunction

  // OP_RTYPE means the operation has no immediate form.
  function automatic logic [5:0] alu_iop(input alu_ctl_t a);
    logic [5:0] op;
    op = OP_RTYPE;
    case (a)
      ALUCTL_ADD:  op = OP_ADDI;
      ALUCTL_ADDU: op = OP_ADDIU;
      ALUCTL_AND:  op = OP_ANDI;
      ALUCTL_OR:   op = OP_ORI;
      ALUCTL_XOR:  op = OP_XORI;
      ALUCTL_SLT:  op = OP_SLTI;
      ALUCTL_SLTU: op = OP_SLTIU;
      default:     op = OP_RTYPE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mips_inst_encoder_if.sv
// Valid/ready bundle between the commit stage, the re-encoder and the trace consumer.
interface mips_inst_encoder_if;
  import mips_core_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_pc;
  decoder_output_t       in_dec;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_word;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  out_err;

  modport master (
    output in_valid, in_pc, in_dec, out_ready,
    input  in_ready, out_valid, out_word, out_pc, out_err
  );

  modport slave (
    input  in_valid, in_pc, in_dec, out_ready,
    output in_ready, out_valid, out_word, out_pc, out_err
  );
endinterface

// File: rtl/mips_enc_fifo.sv
// Synchronous FIFO, DEPTH entries, no bypass; head visible the cycle after a push.
// Push ignored when full, pop ignored when empty; head data reads as 0 while empty.
module mips_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/mips_inst_encoder.sv
// Re-encodes committed decoder records into 32-bit MIPS words and queues {pc, err, word}.
// Latency 1 cycle; in_ready drops only when the FIFO is full (no bypass).
module mips_inst_encoder
  import mips_core_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mips_inst_encoder_if.slave   bus,
  output logic [CNT_WIDTH-1:0] cnt_encoded_o,
  output logic [CNT_WIDTH-1:0] cnt_dropped_o,
  output logic [CNT_WIDTH-1:0] cnt_error_o
);
  localparam int PW = ADDR_WIDTH + 33;

  decoder_output_t       d;
  enc_result_t           enc;
  logic                  bad, off_ok, imm_s_ok, imm_z_ok, zext;
  logic [5:0]            iop;
  logic [ADDR_WIDTH:0]   off;
  logic                  xfer, push, full, empty;
  logic [PW-1:0]         fifo_rdata;
  logic [CNT_WIDTH-1:0]  cnt_enc_q, cnt_enc_d, cnt_drop_q, cnt_drop_d, cnt_err_q, cnt_err_d;

  assign d        = bus.in_dec;
  assign off      = {1'b0, d.branch_target} - {1'b0, bus.in_pc} - {{(ADDR_WIDTH-2){1'b0}}, 3'd4};
  assign off_ok   = (off[1:0] == 2'b00) && ((&off[ADDR_WIDTH:17]) || !(|off[ADDR_WIDTH:17]));
  assign imm_s_ok = (&d.immediate[31:15]) || !(|d.immediate[31:15]);
  assign imm_z_ok = !(|d.immediate[31:16]);
  assign iop      = alu_iop(d.alu_ctl);
  assign zext     = (d.alu_ctl == ALUCTL_AND) || (d.alu_ctl == ALUCTL_OR) || (d.alu_ctl == ALUCTL_XOR);

  always_comb begin
    enc = '0;
    bad = 1'b0;
    if (d.is_jump) begin
      if (d.is_jump_reg)
        enc.word = d.uses_rw ? r_word(d.rs_addr, 5'd0, 5'd31, 5'd0, FN_JALR)
                             : r_word(d.rs_addr, 5'd0, 5'd0, 5'd0, FN_JR);
      else if (!d.uses_rw)        enc.word = j_word(OP_J, d.branch_target[27:2]);
      else if (d.rw_addr == 5'd31) enc.word = j_word(OP_JAL, d.branch_target[27:2]);
      else                        bad = 1'b1;
    end else if (d.is_mem_access) begin
      if (!imm_s_ok)                     bad = 1'b1;
      else if (d.mem_action == MEM_READ) enc.word = i_word(OP_LW, d.rs_addr, d.rw_addr, d.immediate[15:0]);
      else                               enc.word = i_word(OP_SW, d.rs_addr, d.rt_addr, d.immediate[15:0]);
    end else begin
      case (d.alu_ctl)
        ALUCTL_ADD, ALUCTL_ADDU, ALUCTL_SUB, ALUCTL_SUBU, ALUCTL_AND, ALUCTL_OR,
        ALUCTL_XOR, ALUCTL_NOR, ALUCTL_SLT, ALUCTL_SLTU,
        ALUCTL_SLLV, ALUCTL_SRLV, ALUCTL_SRAV: begin
          if (!d.uses_immediate)
            enc.word = r_word(d.rs_addr, d.rt_addr, d.rw_addr, 5'd0, alu_funct(d.alu_ctl));
          // lui is an OR of $0 with a value that only has upper-half bits.
          else if (d.alu_ctl == ALUCTL_OR && !d.uses_rs && d.immediate[15:0] == 16'h0 && d.immediate != 32'h0)
            enc.word = i_word(OP_LUI, 5'd0, d.rw_addr, d.immediate[31:16]);
          else if (iop == OP_RTYPE)               bad = 1'b1;
          else if (zext ? !imm_z_ok : !imm_s_ok)  bad = 1'b1;
          else enc.word = i_word(iop, d.rs_addr, d.rw_addr, d.immediate[15:0]);
        end
        ALUCTL_SLL, ALUCTL_SRL, ALUCTL_SRA: begin
          if (!d.uses_immediate || d.immediate > 32'd31) bad = 1'b1;
          else enc.word = r_word(5'd0, d.rs_addr, d.rw_addr, d.immediate[4:0], alu_funct(d.alu_ctl));
        end
        ALUCTL_BEQ:  enc.word = i_word(OP_BEQ,    d.rs_addr, d.rt_addr, off[17:2]);
        ALUCTL_BNE:  enc.word = i_word(OP_BNE,    d.rs_addr, d.rt_addr, off[17:2]);
        ALUCTL_BLEZ: enc.word = i_word(OP_BLEZ,   d.rs_addr, 5'd0,      off[17:2]);
        ALUCTL_BGTZ: enc.word = i_word(OP_BGTZ,   d.rs_addr, 5'd0,      off[17:2]);
        ALUCTL_BLTZ: enc.word = i_word(OP_REGIMM, d.rs_addr, RT_BLTZ,   off[17:2]);
        ALUCTL_BGEZ: enc.word = i_word(OP_REGIMM, d.rs_addr, RT_BGEZ,   off[17:2]);
        ALUCTL_MTC0_PASS: enc.word = {OP_COP0, RS_MTC0, d.rt_addr, C0_PASS, 11'd0};
        ALUCTL_MTC0_FAIL: enc.word = {OP_COP0, RS_MTC0, d.rt_addr, C0_FAIL, 11'd0};
        ALUCTL_MTC0_DONE: enc.word = {OP_COP0, RS_MTC0, d.rt_addr, C0_DONE, 11'd0};
        default: bad = 1'b1;
      endcase
      if (d.alu_ctl inside {ALUCTL_BEQ, ALUCTL_BNE, ALUCTL_BLEZ, ALUCTL_BGTZ, ALUCTL_BLTZ, ALUCTL_BGEZ} && !off_ok)
        bad = 1'b1;
    end
    if (bad) begin
      enc.err  = 1'b1;
      enc.word = 32'h0;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign xfer          = bus.in_valid && !full;
  assign push          = xfer && d.valid;

  mips_enc_fifo #(.DEPTH(DEPTH), .WIDTH(PW)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i ({bus.in_pc, enc.err, enc.word}),
    .pop_i   (bus.out_ready),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign {bus.out_pc, bus.out_err, bus.out_word} = fifo_rdata;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    cnt_enc_d  = cnt_enc_q;
    cnt_drop_d = cnt_drop_q;
    cnt_err_d  = cnt_err_q;
    if (xfer) begin
      if (!d.valid)    cnt_drop_d = sat_inc(cnt_drop_q);
      else if (enc.err) cnt_err_d = sat_inc(cnt_err_q);
      else             cnt_enc_d  = sat_inc(cnt_enc_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_enc_q  <= '0;
      cnt_drop_q <= '0;
      cnt_err_q  <= '0;
    end else begin
      cnt_enc_q  <= cnt_enc_d;
      cnt_drop_q <= cnt_drop_d;
      cnt_err_q  <= cnt_err_d;
    end
  end

  assign cnt_encoded_o = cnt_enc_q;
  assign cnt_dropped_o = cnt_drop_q;
  assign cnt_error_o   = cnt_err_q;
endmodule

// File: tb/tb_mips_inst_encoder.sv
// Directed vector table for the re-encoder plus backpressure, drop and reset sequences.
module tb_mips_inst_encoder;
  import mips_core_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] cnt_enc, cnt_drop, cnt_err;
  int n_checks = 0;
  int n_fail   = 0;

  mips_inst_encoder_if bus();

  mips_inst_encoder #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .cnt_encoded_o (cnt_enc),
    .cnt_dropped_o (cnt_drop),
    .cnt_error_o   (cnt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    decoder_output_t dec;
    logic [31:0]     pc;
    logic [31:0]     word;
    logic            err;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_word_q[$];
  logic [31:0] exp_pc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic decoder_output_t mk(alu_ctl_t alu, logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rw, logic ui, logic [31:0] imm);
    decoder_output_t r;
    r = '0;
    r.valid = 1'b1;
    r.alu_ctl = alu;
    r.rs_addr = rs;
    r.rt_addr = rt;
    r.rw_addr = rw;
    r.uses_rs = 1'b1;
    r.uses_rw = 1'b1;
    r.uses_immediate = ui;
    r.immediate = imm;
    return r;
  endfunction

  task automatic add_vec(input decoder_output_t dec, input logic [31:0] pc,
                         input logic [31:0] word, input logic err);
    vec_t v;
    v.dec = dec; v.pc = pc; v.word = word; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    decoder_output_t d;
    int exp_enc, exp_err, k;
    logic acc_in, acc_out;

    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_dec = '0; bus.out_ready = 1'b0;

    d = mk(ALUCTL_ADD, 1, 2, 3, 0, 0);                          add_vec(d, 32'h100, 32'h00221820, 0);
    d = mk(ALUCTL_BEQ, 4, 5, 0, 0, 0); d.branch_target = 32'hF0; add_vec(d, 32'h100, 32'h1085FFFB, 0);
    d.branch_target = 32'hF2;                                   add_vec(d, 32'h100, 32'h0, 1);
    d = mk(ALUCTL_OR, 0, 0, 8, 1, 32'h12340000); d.uses_rs = 0; add_vec(d, 32'h104, 32'h3C081234, 0);
    d = mk(ALUCTL_OR, 0, 0, 8, 1, 32'h0); d.uses_rs = 0;        add_vec(d, 32'h108, 32'h34080000, 0);
    d = mk(ALUCTL_ADD, 6, 0, 5, 1, 32'hFFFFFFFF);               add_vec(d, 32'h10C, 32'h20C5FFFF, 0);
    d = mk(ALUCTL_AND, 1, 0, 2, 1, 32'h00010000);               add_vec(d, 32'h110, 32'h0, 1);
    d = mk(ALUCTL_SLL, 3, 0, 2, 1, 32'd4);                      add_vec(d, 32'h114, 32'h00031100, 0);
    d = mk(ALUCTL_SLL, 3, 0, 2, 1, 32'd32);                     add_vec(d, 32'h118, 32'h0, 1);
    d = mk(ALUCTL_ADD, 29, 0, 9, 1, 32'd8); d.is_mem_access = 1; d.mem_action = MEM_READ;
    add_vec(d, 32'h11C, 32'h8FA90008, 0);
    d = mk(ALUCTL_ADD, 29, 9, 0, 1, 32'hFFFFFFFC); d.is_mem_access = 1; d.mem_action = MEM_WRITE;
    add_vec(d, 32'h120, 32'hAFA9FFFC, 0);
    d = mk(ALUCTL_NOP, 0, 0, 0, 0, 0); d.is_jump = 1; d.uses_rw = 0; d.branch_target = 32'h00400040;
    add_vec(d, 32'h124, 32'h08100010, 0);
    d.uses_rw = 1; d.rw_addr = 31;                              add_vec(d, 32'h128, 32'h0C100010, 0);
    d = mk(ALUCTL_NOP, 31, 0, 0, 0, 0); d.is_jump = 1; d.is_jump_reg = 1; d.uses_rw = 0;
    add_vec(d, 32'h12C, 32'h03E00008, 0);
    d = mk(ALUCTL_NOP, 0, 0, 0, 0, 0);                          add_vec(d, 32'h130, 32'h0, 1);
    d = mk(ALUCTL_BGEZ, 4, 0, 0, 0, 0); d.branch_target = 32'h108; add_vec(d, 32'h100, 32'h04810001, 0);
    d = mk(ALUCTL_MTC0_PASS, 0, 2, 0, 0, 0);                    add_vec(d, 32'h134, 32'h40828800, 0);
    d = mk(ALUCTL_BEQ, 1, 2, 0, 0, 0); d.branch_target = 32'h20004; add_vec(d, 32'h0, 32'h0, 1);
    d = mk(ALUCTL_SLT, 1, 0, 2, 1, 32'h00008000);               add_vec(d, 32'h138, 32'h0, 1);
    d = mk(ALUCTL_NOR, 1, 2, 3, 0, 0);                          add_vec(d, 32'h13C, 32'h00221827, 0);
    d = mk(ALUCTL_SLTU, 1, 2, 3, 0, 0);                         add_vec(d, 32'h140, 32'h0022182B, 0);

    // Reset state
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_word",  64'(bus.out_word),  64'd0);
    check("rst_out_pc",    64'(bus.out_pc),    64'd0);
    check("rst_out_err",   64'(bus.out_err),   64'd0);
    check("rst_counters",  {16'd0, cnt_enc, cnt_drop, cnt_err}, 64'd0);

    // Vector table: one transfer, check head next cycle, then pop.
    exp_enc = 0; exp_err = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.in_valid = 1'b1; bus.in_pc = vecs[i].pc; bus.in_dec = vecs[i].dec;
      step();
      bus.in_valid = 1'b0;
      if (vecs[i].err) exp_err++; else exp_enc++;
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("vec%0d_word", i),  64'(bus.out_word),  64'(vecs[i].word));
      check($sformatf("vec%0d_err", i),   64'(bus.out_err),   64'(vecs[i].err));
      check($sformatf("vec%0d_pc", i),    64'(bus.out_pc),    64'(vecs[i].pc));
      check($sformatf("vec%0d_cnt_enc", i), 64'(cnt_enc), 64'(exp_enc));
      check($sformatf("vec%0d_cnt_err", i), 64'(cnt_err), 64'(exp_err));
      step();
      check($sformatf("vec%0d_popped", i), 64'(bus.out_valid), 64'd0);
    end

    // Backpressure: fill, no bypass when full, then stream with pointer wrap.
    bus.out_ready = 1'b0;
    k = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_valid = 1'b1; bus.in_pc = 32'h1000 + 32'(k * 4); bus.in_dec = mk(ALUCTL_ADD, 1, 2, 5'(k), 0, 0);
      exp_word_q.push_back(32'h00220020 | (32'(k) << 11));
      exp_pc_q.push_back(32'h1000 + 32'(k * 4));
      k++;
      step();
    end
    bus.in_valid = 1'b0;
    check("full_in_ready",  64'(bus.in_ready),  64'd0);
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = 1'b1; bus.in_pc = 32'h1000 + 32'(k * 4); bus.in_dec = mk(ALUCTL_ADD, 1, 2, 5'(k), 0, 0);
      acc_in = bus.in_ready;
      acc_out = bus.out_valid;
      if (c == 0) check("no_bypass_in_ready", 64'(acc_in), 64'd0);
      if (acc_out && exp_word_q.size() > 0) begin
        check($sformatf("stream%0d_word", c), 64'(bus.out_word), 64'(exp_word_q.pop_front()));
        check($sformatf("stream%0d_pc", c),   64'(bus.out_pc),   64'(exp_pc_q.pop_front()));
      end
      if (acc_in) begin
        exp_word_q.push_back(32'h00220020 | (32'(k) << 11));
        exp_pc_q.push_back(32'h1000 + 32'(k * 4));
        k++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 2 * DEPTH; c++) begin
      if (bus.out_valid && exp_word_q.size() > 0) begin
        check($sformatf("drain%0d_word", c), 64'(bus.out_word), 64'(exp_word_q.pop_front()));
        check($sformatf("drain%0d_pc", c),   64'(bus.out_pc),   64'(exp_pc_q.pop_front()));
      end
      step();
    end
    check("drain_left_in_model", 64'(exp_word_q.size()), 64'd0);
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);

    // Dropped records
    for (int i = 0; i < 3; i++) begin
      d = mk(ALUCTL_ADD, 1, 2, 3, 0, 0); d.valid = 1'b0;
      bus.in_valid = 1'b1; bus.in_dec = d;
      step();
      check($sformatf("drop%0d_out_valid", i), 64'(bus.out_valid), 64'd0);
    end
    bus.in_valid = 1'b0;
    check("cnt_dropped", 64'(cnt_drop), 64'd3);

    // Reset with 2 entries queued and a transfer on the reset cycle
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_dec = mk(ALUCTL_ADD, 1, 2, 3, 0, 0);
      step();
    end
    check("prereset_out_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    check("midrst_counters",  {16'd0, cnt_enc, cnt_drop, cnt_err}, 64'd0);
    check("midrst_out_word",  64'(bus.out_word),  64'd0);
    step();
    check("midrst_lost_xfer", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
